// File: rtl/adc_conditioner_pkg.sv
// Shared definitions for the ADC conditioning pipeline: default parameter
// values, the mode encoding and a helper for channel-tag width.
package adc_conditioner_pkg;

    localparam int ADC_W_DEF      = 12;
    localparam int FRAC_SHIFT_DEF = 2;
    localparam int OUT_W_DEF      = 23;
    localparam int N_CH_DEF       = 2;
    localparam int AVG_SHIFT_DEF  = 8;

    // Meaning of the mode input.
    typedef enum logic {
        MODE_FIXED = 1'b0,   // remove mid-scale only
        MODE_DC    = 1'b1    // additionally subtract the tracked per-channel DC
    } mode_e;

    // Channel tag width; a single-channel build still carries a 1-bit tag.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Saturating narrow: reduces a signed value to a smaller signed width,
// clamping to the output rails and flagging when clamping happened.
module sat_narrow #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  wide,
    output logic signed [OUT_W-1:0] narrow,
    output logic                    clipped
);

    // Bits that must all equal the sign for the value to fit in OUT_W.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = wide[IN_W-1:OUT_W-1];

    // Pass the low bits through, or clamp to the rail matching the sign.
    always_comb begin
        // NOTE: outputs take a default before any branch so no path infers a latch.
        narrow  = wide[OUT_W-1:0];
        clipped = 1'b0;
        if (!(&top_bits) && (|top_bits)) begin
            clipped = 1'b1;
            narrow  = wide[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/adc_conditioner.sv
// Two-stage ADC conditioner: stage 1 centres and scales the offset-binary
// sample, stage 2 optionally subtracts a per-channel DC estimate, saturates
// and presents the result. Both stages stall together under back-pressure.
module adc_conditioner
    import adc_conditioner_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int N_CH       = N_CH_DEF,
    parameter int AVG_SHIFT  = AVG_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      dc_clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADC_W-1:0]          in_data,
    input  logic [ch_width(N_CH)-1:0] in_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic [ch_width(N_CH)-1:0] out_ch,
    output logic                      sat_flag,
    input  logic                      sat_clr
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int ACC_W = OUT_W + AVG_SHIFT;

    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_c;
    logic [CH_W-1:0]         s1_ch;
    logic signed [ACC_W-1:0] acc [N_CH];

    logic                    s2_adv;
    logic                    dc_mode;
    logic [ADC_W-1:0]        centred;
    logic signed [ACC_W-1:0] c_in;
    logic [CH_W-1:0]         ch_in;
    logic signed [ACC_W-1:0] dc;
    logic signed [ACC_W:0]   d;
    logic signed [OUT_W-1:0] d_sat;
    logic                    d_clipped;

    // The output register can take a new value when empty or being drained;
    // stage 1 can load when it is empty or moving into the output register.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign dc_mode  = (mode_e'(mode) == MODE_DC);

    // Offset binary to two's complement is an MSB flip; then sign-extend and scale.
    assign centred = {~in_data[ADC_W-1], in_data[ADC_W-2:0]};
    assign c_in    = {{(ACC_W-ADC_W){centred[ADC_W-1]}}, centred} << FRAC_SHIFT;

    // Tags outside the configured channel range are folded onto channel 0.
    if ((1 << CH_W) > N_CH) begin : g_ch_fold
        assign ch_in = (in_ch < CH_W'(N_CH)) ? in_ch : '0;
    end else begin : g_ch_pass
        assign ch_in = in_ch;
    end

    // The DC estimate is read before this sample's own accumulator update.
    assign dc = acc[s1_ch] >>> AVG_SHIFT;
    assign d  = {s1_c[ACC_W-1], s1_c} - (dc_mode ? {dc[ACC_W-1], dc} : '0);

    sat_narrow #(
        .IN_W  (ACC_W + 1),
        .OUT_W (OUT_W)
    ) u_sat (
        .wide    (d),
        .narrow  (d_sat),
        .clipped (d_clipped)
    );

    // Stage 1: capture the centred, scaled sample and its channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_ch    <= '0;
        end else if (in_ready) begin
            // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
            s1_valid <= in_valid;
            s1_c     <= c_in;
            s1_ch    <= ch_in;
        end
    end

    // Stage 2: register the saturated result when the output can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= d_sat;
                out_ch   <= s1_ch;
            end
        end
    end

    // Sticky saturation flag; a new saturation wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s2_adv && s1_valid && d_clipped) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    // Per-channel DC tracker: leaky integrator updated as samples leave stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator array is reset explicitly; the tracker must restart from zero, so it is flops, not RAM.
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
        end else if (dc_clr) begin
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
        end else if (s2_adv && s1_valid && dc_mode) begin
            acc[s1_ch] <= acc[s1_ch] + s1_c - dc;
        end
    end

endmodule

// File: tb/tb_adc_conditioner.sv
// Self-checking bench for adc_conditioner. A default-width instance and a
// 14-bit-output instance share all inputs; a behavioural model of the
// centring, DC tracking and clipping predicts every result in order.
module tb_adc_conditioner;

    localparam int ADC_W      = 12;
    localparam int FRAC_SHIFT = 2;
    localparam int OUT_W      = 23;
    localparam int OUT_W_N    = 14;
    localparam int N_CH       = 2;
    localparam int AVG_SHIFT  = 8;
    localparam int CH_W       = 1;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               mode      = 1'b0;
    logic               dc_clr    = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b1;
    logic               sat_clr   = 1'b0;
    logic [ADC_W-1:0]   in_data   = '0;
    logic [CH_W-1:0]    in_ch     = '0;

    logic               in_ready, out_valid, sat_flag;
    logic [OUT_W-1:0]   out_data;
    logic [CH_W-1:0]    out_ch;
    logic               in_ready_n, out_valid_n, sat_flag_n;
    logic [OUT_W_N-1:0] out_data_n;
    logic [CH_W-1:0]    out_ch_n;

    adc_conditioner #(
        .ADC_W(ADC_W), .FRAC_SHIFT(FRAC_SHIFT), .OUT_W(OUT_W), .N_CH(N_CH), .AVG_SHIFT(AVG_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dc_clr(dc_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    adc_conditioner #(
        .ADC_W(ADC_W), .FRAC_SHIFT(FRAC_SHIFT), .OUT_W(OUT_W_N), .N_CH(N_CH), .AVG_SHIFT(AVG_SHIFT)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dc_clr(dc_clr),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_ch(out_ch_n),
        .sat_flag(sat_flag_n), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int raw; int ch; int cyc; } sample_t;
    typedef struct { longint v; longint vn; int ch; } result_t;

    sample_t exp_q[$];
    result_t got_q[$];
    longint  macc[N_CH];
    int      checks    = 0;
    int      errors    = 0;
    int      cyc       = 0;
    bit      check_lat = 1'b0;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clip(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N_CH; i++) macc[i] = 0;
    endfunction

    // One clock cycle: apply inputs, score any output transfer, note any input transfer.
    task automatic drive_cycle(input bit v, input int raw, input int ch, input bit ordy, output bit accepted);
        sample_t s;
        result_t r;
        longint  c, dc, d, e_w, e_n;
        in_valid  = v;
        in_data   = ADC_W'(raw);
        in_ch     = CH_W'(ch);
        out_ready = ordy;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got out_data=%0d, expected no result", $signed(out_data));
            end else begin
                s  = exp_q.pop_front();
                c  = longint'(s.raw - (1 << (ADC_W - 1))) * (longint'(1) << FRAC_SHIFT);
                dc = floor_div(macc[s.ch], longint'(1) << AVG_SHIFT);
                d  = (mode == 1'b1) ? c - dc : c;
                if (mode == 1'b1) macc[s.ch] = macc[s.ch] + c - dc;
                e_w = clip(d, OUT_W);
                e_n = clip(d, OUT_W_N);
                if (longint'($signed(out_data)) !== e_w || int'(out_ch) !== s.ch) begin
                    errors++;
                    $display("FAIL result_wide: got %0d ch%0d, expected %0d ch%0d", $signed(out_data), out_ch, e_w, s.ch);
                end
                checks++;
                if (out_valid_n !== 1'b1 || longint'($signed(out_data_n)) !== e_n || int'(out_ch_n) !== s.ch) begin
                    errors++;
                    $display("FAIL result_narrow: got v=%0b %0d ch%0d, expected v=1 %0d ch%0d",
                             out_valid_n, $signed(out_data_n), out_ch_n, e_n, s.ch);
                end
                if (check_lat) begin
                    checks++;
                    if (cyc != s.cyc + 2) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected 2", cyc - s.cyc);
                    end
                end
                r.v  = longint'($signed(out_data));
                r.vn = longint'($signed(out_data_n));
                r.ch = int'(out_ch);
                got_q.push_back(r);
            end
        end
        if (accepted) begin
            s.raw = raw;
            s.ch  = ch;
            s.cyc = cyc;
            exp_q.push_back(s);
        end
        @(negedge clk);
        cyc++;
    endtask

    // Idle the input with the output open until every outstanding result is scored.
    task automatic drain();
        bit a;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            drive_cycle(1'b0, 0, 0, 1'b1, a);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dc_clr   = 1'b0;
        sat_clr  = 1'b0;
        exp_q.delete();
        got_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_flag !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b rdy=%0b sat=%0b data=%0h ch=%0d, expected 0 1 0 0 0",
                     out_valid, in_ready, sat_flag, out_data, out_ch);
        end
        checks++;
        if (dut.acc[0] !== '0 || dut.acc[1] !== '0) begin
            errors++;
            $display("FAIL reset_acc: got %0h %0h, expected 0 0", dut.acc[0], dut.acc[1]);
        end
        apply_reset();
    endtask

    task automatic test_fixed();
        bit a;
        apply_reset();
        mode      = 1'b0;
        check_lat = 1'b1;
        drive_cycle(1'b1, 'h800, 0, 1'b1, a);
        drive_cycle(1'b1, 'hFFF, 0, 1'b1, a);
        drive_cycle(1'b1, 'h000, 0, 1'b1, a);
        drain();
        check_lat = 1'b0;
        checks++;
        if (got_q.size() != 3 || got_q[0].v != 0 || got_q[1].v != 8188 || got_q[2].v != -8192) begin
            errors++;
            $display("FAIL fixed_values: got %0d results, expected 0 8188 -8192", got_q.size());
        end
        checks++;
        if (out_data !== 23'h7FE000) begin
            errors++;
            $display("FAIL fixed_min_bits: got %0h, expected 7fe000", out_data);
        end
    endtask

    task automatic test_decay();
        bit     a;
        longint first, second, prev, last;
        int     n0, bad_mono, bad_ch1;
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < 4096; k++) begin
            drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
            drive_cycle(1'b1, 'h800, 1, 1'b1, a);
        end
        drain();
        n0 = 0; bad_mono = 0; bad_ch1 = 0;
        first = 0; second = 0; prev = 0; last = 0;
        foreach (got_q[i]) begin
            if (got_q[i].ch == 0) begin
                if (n0 == 0) first = got_q[i].v;
                if (n0 == 1) second = got_q[i].v;
                if (n0 > 0 && got_q[i].v > prev) bad_mono++;
                prev = got_q[i].v;
                last = got_q[i].v;
                n0++;
            end else if (got_q[i].v != 0) begin
                bad_ch1++;
            end
        end
        checks++;
        if (first != 2048 || second != 2040) begin
            errors++;
            $display("FAIL decay_start: got %0d %0d, expected 2048 2040", first, second);
        end
        checks++;
        if (bad_mono != 0 || last != 0) begin
            errors++;
            $display("FAIL decay_shape: got %0d rises, final %0d, expected 0 rises, final 0", bad_mono, last);
        end
        checks++;
        if (bad_ch1 != 0) begin
            errors++;
            $display("FAIL decay_ch1: got %0d nonzero results, expected 0", bad_ch1);
        end
    endtask

    task automatic test_stall();
        bit a;
        int idx, lows, k;
        int raws[6];
        int chs[6];
        apply_reset();
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raws[i] = int'($urandom_range(0, 4095));
            chs[i]  = int'($urandom_range(0, N_CH - 1));
        end
        idx = 0; lows = 0; k = 0;
        while ((idx < 6 || k < 5) && k < 40) begin
            drive_cycle(idx < 6, (idx < 6) ? raws[idx] : 0, (idx < 6) ? chs[idx] : 0, k >= 5, a);
            if (k < 5 && !a) lows++;
            if (a) idx++;
            k++;
        end
        drain();
        checks++;
        if (lows != 3) begin
            errors++;
            $display("FAIL stall_ready: got %0d refused cycles, expected 3", lows);
        end
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d results, expected 6", got_q.size());
        end
    endtask

    task automatic test_random();
        bit a;
        for (int r = 0; r < 4; r++) begin
            mode = r[0];
            for (int k = 0; k < 300; k++)
                drive_cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)),
                            int'($urandom_range(0, N_CH - 1)), $urandom_range(0, 9) < 7, a);
            drain();
        end
    endtask

    task automatic test_dc_clr();
        bit a;
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
            drive_cycle(1'b1, 'h600, 1, 1'b1, a);
        end
        drain();
        drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
        dc_clr = 1'b1;
        drive_cycle(1'b0, 0, 0, 1'b1, a);
        dc_clr = 1'b0;
        checks++;
        if (dut.acc[0] !== '0 || dut.acc[1] !== '0) begin
            errors++;
            $display("FAIL dc_clr_acc: got %0h %0h, expected 0 0", dut.acc[0], dut.acc[1]);
        end
        drain();
        model_clear();
        got_q.delete();
        drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
        drive_cycle(1'b1, 'h600, 1, 1'b1, a);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0].v != 2048 || got_q[1].v != -2048) begin
            errors++;
            $display("FAIL dc_clr_restart: got %0d results, expected 2048 -2048", got_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit a;
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < 20; k++) drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
        checks++;
        if (out_valid !== 1'b1 || dut.acc[0] === '0) begin
            errors++;
            $display("FAIL midreset_pre: got v=%0b acc=%0h, expected v=1 acc nonzero", out_valid, dut.acc[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut.acc[0] !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b rdy=%0b acc=%0h, expected 0 1 0", out_valid, in_ready, dut.acc[0]);
        end
        exp_q.delete();
        got_q.delete();
        model_clear();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_cycle(1'b1, 'hA00, 0, 1'b1, a);
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0].v != 2048) begin
            errors++;
            $display("FAIL midreset_first: got %0d results, expected one 2048", got_q.size());
        end
    endtask

    task automatic test_saturation();
        bit a;
        apply_reset();
        mode = 1'b1;
        for (int k = 0; k < 3000; k++) drive_cycle(1'b1, 'h000, 0, 1'b1, a);
        drain();
        checks++;
        if (sat_flag_n !== 1'b0) begin
            errors++;
            $display("FAIL sat_at_rail: got %0b, expected 0", sat_flag_n);
        end
        got_q.delete();
        drive_cycle(1'b1, 'hFFF, 0, 1'b1, a);
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0].vn != 8191 || sat_flag_n !== 1'b1 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_set: got narrow flag=%0b wide flag=%0b, expected 1 0 with 8191", sat_flag_n, sat_flag);
        end
        sat_clr = 1'b1;
        drive_cycle(1'b0, 0, 0, 1'b1, a);
        sat_clr = 1'b0;
        checks++;
        if (sat_flag_n !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %0b, expected 0", sat_flag_n);
        end
        drive_cycle(1'b1, 'hFFF, 0, 1'b1, a);
        sat_clr = 1'b1;
        drive_cycle(1'b0, 0, 0, 1'b1, a);
        sat_clr = 1'b0;
        checks++;
        if (sat_flag_n !== 1'b1) begin
            errors++;
            $display("FAIL sat_priority: got %0b, expected 1", sat_flag_n);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_decay();
        test_stall();
        test_random();
        test_dc_clr();
        test_reset_midstream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/adc_conditioner.md
ADC_CONDITIONER -- requirements
Module: adc_conditioner

Interface
REQ-001 Parameter ADC_W, default 12, SHALL set raw ADC sample width in bits; legal range 8..16.
REQ-002 Parameter FRAC_SHIFT, default 2, SHALL set the left shift applied to the centred sample.
REQ-003 Parameter OUT_W, default 23, SHALL set signed output width; legal range OUT_W >= ADC_W+FRAC_SHIFT.
REQ-004 Parameter N_CH, default 2, SHALL set the number of interleaved channels; legal range 1..8.
REQ-005 Parameter AVG_SHIFT, default 8, SHALL set the DC-tracker time constant (2^AVG_SHIFT samples).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = fixed mid-scale removal, 1 = adaptive DC removal
- dc_clr  in  1  synchronous pulse; zeroes all DC accumulators
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_data  in  ADC_W  offset-binary ADC sample
- in_ch  in  clog2(N_CH), min 1  channel tag of sample
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed two's-complement result
- out_ch  out  clog2(N_CH), min 1  channel tag of result
- sat_flag  out  1  sticky; set when any result saturated
- sat_clr  in  1  synchronous pulse; clears sat_flag

Function
REQ-007 A transfer SHALL occur on a rising edge where valid and ready are both high, on either port.
REQ-008 in_ready SHALL equal (!s1_valid || !out_valid || out_ready); the whole pipeline stalls as one, and no sample is dropped or duplicated.
REQ-009 Stage 1 SHALL register c = (in_data - 2^(ADC_W-1)) * 2^FRAC_SHIFT, sign-extended to OUT_W+AVG_SHIFT bits, together with in_ch.
REQ-010 Stage 2 SHALL compute d = c - dc[ch] when mode=1 and d = c when mode=0, where dc[ch] = acc[ch] >>> AVG_SHIFT (arithmetic shift).
REQ-011 out_data SHALL be d saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-012 sat_flag SHALL be set on the cycle a saturated result is registered; set takes priority over a simultaneous sat_clr.
REQ-013 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled; throughput SHALL be one sample per cycle.
REQ-014 On each stage-2 advance with mode=1, the block SHALL update acc[ch] <= acc[ch] + c - (acc[ch] >>> AVG_SHIFT); d SHALL use the pre-update dc[ch].
REQ-015 With mode=0, acc[] SHALL hold its value.
REQ-016 dc_clr SHALL zero all acc[] and SHALL override an update in the same cycle; data in flight is unaffected.
REQ-017 A mode change SHALL take effect for the sample entering stage 2 on that edge; there is no flush.
REQ-018 An in_ch value >= N_CH SHALL be treated as channel 0.

Reset
REQ-019 While rst_n is low: out_valid, stage-1 valid, out_data, out_ch, sat_flag and all acc[] SHALL be 0, and in_ready SHALL read 1.
REQ-020 Reset asserted mid-stream SHALL discard in-flight samples; the first transfer after release SHALL behave as if from power-up.

Structure
REQ-021 The shared package SHALL hold default parameter values and the mode encoding constants MODE_FIXED=0 and MODE_DC=1.
REQ-022 The saturating narrow step SHALL be a sub-module sat_narrow, parametrised by input and output widths.
REQ-023 acc[] SHALL be a per-channel register array N_CH x (OUT_W+AVG_SHIFT) bits, with no RAM inference required.

Verification
REQ-024 Defaults, mode=0, out_ready=1, inputs 0x800, 0xFFF, 0x000 -> out_data 0, 8188 and 0x7FE000 (-8192), each 2 cycles after its input.
REQ-025 mode=1, ch0 held at 0xA00 after reset:
- first output 2048, second 2040;
- monotonic decay toward 0 within 4096 samples;
- ch1 interleaved at 0x800 always outputs 0.
REQ-026 out_ready held low for 5 cycles while 6 samples are offered -> in_ready drops after the pipeline fills; all 6 results appear in order with correct out_ch and no loss.
REQ-027 OUT_W=14, mode=1: 3000 samples of 0x000 on ch0, then 0xFFF -> out_data 8191, sat_flag=1; sat_clr clears sat_flag only on a cycle with no new saturation.
REQ-028 rst_n pulsed low mid-stream with acc nonzero and out_valid=1 -> out_valid=0 immediately, acc=0; the next 0xA00 on ch0 outputs 2048.
REQ-029 dc_clr asserted in the same cycle as a mode=1 update -> all acc[] read 0 on the next cycle.
